if_fetch_stage: RTL

Instruction fetch stage of the 5-stage RV32I pipeline, placed directly upstream of the IF/ID pipeline register. It owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and buffers the returned word. It presents `{pc, pc+4, instr}` to IF/ID and replaces that triple with a NOP bubble whenever no instruction is ready. Branch/jump redirects from EX override the sequential PC and cancel any fetch already in flight.

---
 rtl/if_fetch_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage of the RV32I pipeline.
// Owns the PC, keeps at most one instruction-memory request in flight,
// buffers the returned word and presents {pc, pc+4, instr} to IF/ID,
// substituting a NOP bubble whenever no instruction is ready.
// EX redirects override the sequential PC and cancel in-flight fetches.
//
// Optional feature macro: IF_FETCH_PERF_EN
//   When defined, adds perf_fetched / perf_discarded event counters.
//
// Handshake semantics: a request transfers on a rising clk edge where
// imem_req_valid and imem_req_ready are both high; once raised,
// imem_req_valid/imem_req_addr stay stable until accepted unless a
// redirect cancels the request. imem_resp_valid is a one-cycle strobe
// (no back-pressure) arriving at least one cycle after acceptance.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_stall,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_p4,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic [1:0]  o_dbg_state
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    // REQ: request pending; WAIT: request accepted, awaiting word;
    // HOLD: word buffered and presented; DISCARD: awaiting a stale word.
    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_hold_instr;
    logic [31:0] w_hold_nxt;
    logic [31:0] w_pc_seq;
    logic [31:0] w_redirect_pc;
    logic        w_consume;
    logic        w_discard;
    logic        w_req_valid;
    logic        w_unused_redirect_lsbs;

    // Sequential successor wraps modulo 2^32; redirect targets are forced
    // onto a word boundary so the fetch address is always aligned.
    assign w_pc_seq               = r_pc + 32'd4;
    assign w_redirect_pc          = {redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsbs = ^redirect_pc[1:0];

    // A request is offered in REQ, or in HOLD when the buffered word is
    // consumed this cycle (so the next fetch overlaps the hand-off). A
    // redirect always suppresses the request, and reset holds it low.
    assign w_req_valid = rstn && !redirect_valid &&
                         ((r_state == ST_REQ) ||
                          ((r_state == ST_HOLD) && !if_stall));

    assign imem_req_valid = w_req_valid;
    // In HOLD the request is for the instruction after the one presented.
    assign imem_req_addr  = (r_state == ST_HOLD) ? w_pc_seq : r_pc;

    // Next-state, next-PC and buffer-load decode; redirect wins everywhere.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_hold_nxt  = r_hold_instr;
        w_consume   = 1'b0;
        w_discard   = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end else if (imem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                    if (imem_resp_valid) begin
                        // The outstanding word arrives now: drop it and
                        // the target can be requested immediately.
                        w_discard   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (imem_resp_valid) begin
                    w_hold_nxt  = imem_resp_data;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = ST_REQ;
                end else if (!if_stall) begin
                    w_consume   = 1'b1;
                    w_pc_nxt    = w_pc_seq;
                    w_state_nxt = imem_req_ready ? ST_WAIT : ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_pc;
                end
                // Only one request is ever outstanding, so the first word
                // seen here is the stale one; leaving on it avoids waiting
                // for a response that will never come.
                if (imem_resp_valid) begin
                    w_discard   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
    end

    // State, PC and instruction buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_REQ;
            r_pc         <= {RESET_PC[31:2], 2'b00};
            r_hold_instr <= NOP_INSTR;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_nxt;
        end
    end

    // IF/ID triple is decoded from state only; bubble outside HOLD.
    always_comb begin
        if_valid = 1'b0;
        if_instr = NOP_INSTR;
        if_pc    = 32'd0;
        if_pc_p4 = 32'd0;
        if (r_state == ST_HOLD) begin
            if_valid = 1'b1;
            if_instr = r_hold_instr;
            if_pc    = r_pc;
            if_pc_p4 = w_pc_seq;
        end
    end

    assign o_dbg_state = r_state;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;

    // Event counters: consumed instructions and redirect-dropped responses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_perf_fetched   <= 32'd0;
            r_perf_discarded <= 32'd0;
        end else begin
            if (w_consume) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_discard) begin
                r_perf_discarded <= r_perf_discarded + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`endif

endmodule
